action_lu_seq: RTL and testbench
================================

# action_lu_seq

Sequential, parametrised logic unit for the action unit. It applies one per-field action to every field of a multi-field packet header and updates the header's field-presence bitmap. Fields are processed one per clock by a small FSM, with valid/ready handshakes on both sides. Beyond pass, remove and add/modify, it adds wrapping increment, saturating decrement and illegal-action error reporting. It sits between the header parser and the header rebuilder.

## Interface
- WIDTH, 8, bits per header field
- NUM_FIELDS, 4, number of header fields (≥2); the field index counter is $clog2(NUM_FIELDS) bits
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  upstream transaction valid
- in_ready  output  1  block can accept a transaction
- in_header  input  NUM_FIELDS*WIDTH  field i at [i*WIDTH +: WIDTH]
- in_bitmap  input  NUM_FIELDS  bit i = field i present
- in_control  input  NUM_FIELDS*4  action for field i at [i*4 +: 4]
- in_data  input  NUM_FIELDS*WIDTH  replacement value for field i
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- out_header  output  NUM_FIELDS*WIDTH  processed header
- out_bitmap  output  NUM_FIELDS  processed bitmap
- out_error  output  1  at least one field had an illegal action this transaction

## Operation
- One clock domain (clk). Reset is synchronous and active-high (rst); the polarity and synchronicity are fixed.
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, capture all inputs into working registers, set idx=0, clear the error flag, go to RUN.
- RUN: each cycle apply the action to field idx and its bitmap bit, then idx+1. On idx==NUM_FIELDS-1, apply and go to DONE.
- DONE: out_valid=1; outputs show the working registers. On out_ready, go to IDLE.
- Action codes for field f, bitmap bit b, data d:
  - 0000 No_Change: f, b unchanged.
  - 0001 Remove: f unchanged, b=0.
  - 0010 Add_Modify: f=d, b=1.
  - 0011 Increment: if b=1, f=f+1 modulo 2^WIDTH (0xFF→0x00 at WIDTH=8). If b=0, f unchanged and error set.
  - 0100 Decrement: if b=1, f=f-1 saturating at 0. If b=0, f unchanged and error set.
  - Any other code: f=0, b=0, error set.
- out_error is sticky within a transaction and cleared only at capture.
- in_valid is ignored outside IDLE. The input buses are only sampled at capture.

## Timing
- Reset:
  - state=IDLE, idx=0.
  - out_valid=0, out_header=0, out_bitmap=0, out_error=0.
  - in_ready=0 while rst is high, 1 from the first cycle after rst deasserts.
- Latency: capture on the edge ending cycle k, then RUN during cycles k+1..k+NUM_FIELDS. out_valid first high in cycle k+NUM_FIELDS+1.
- Throughput: no overlap between transactions. With out_ready held high, the minimum period is NUM_FIELDS+2 cycles.
- Backpressure: while out_valid=1 and out_ready=0, out_header, out_bitmap and out_error stay stable and in_ready=0.
- Handoff: out_ready in DONE causes out_valid=0 and in_ready=1 in the next cycle.
- Reset mid-RUN or mid-DONE: the transaction is abandoned and never output, and all outputs take their reset values the next cycle.
- out_header, out_bitmap and out_error are driven only from registers, with no combinational path from inputs.

## Test plan
- Reset: hold rst 3 cycles with in_valid=1 → all outputs 0 and in_ready=0 throughout; in_ready=1 the cycle after release; nothing captured.
- Mixed actions (WIDTH=8, N=4):
  - Stimulus: header fields 3..0 = 0x44,0x33,0x22,0x11; bitmap 1111; controls 3..0 = Increment, Add_Modify (d=0xAA), Remove, No_Change.
  - Response: header 0x45,0xAA,0x22,0x11; bitmap 1101; error 0; out_valid in cycle k+5.
- Arithmetic bounds: field0=0xFF Increment, field1=0x00 Decrement, field2=0x05 Decrement, all present → 0x00, 0x00, 0x04; error 0.
- Errors:
  - Stimulus: field2 control 1000, field3 Increment with bitmap bit3=0.
  - Response: field2=0x00 with bit2=0; field3 unchanged with bit3=0; error 1.
  - A following clean transaction returns error 0.
- Backpressure: hold out_ready=0 for 10 cycles in DONE while toggling in_valid and the inputs → outputs stable, in_ready=0, no capture. Pulse out_ready → out_valid=0 and in_ready=1 next cycle.
- Reset mid-operation: assert rst in cycle k+2 of a transaction → out_valid never rises and outputs are 0. A new transaction after release gives the correct result at cycle k'+5.

Source files
------------

// File: rtl/action_lu_seq.sv
// Sequential per-field action unit: captures a header, walks its fields one per
// clock applying each field's action, then holds the result until downstream accepts.
module action_lu_seq #(
   parameter int WIDTH      = 8,
   parameter int NUM_FIELDS = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [NUM_FIELDS*WIDTH-1:0]   in_header,
   input  logic [NUM_FIELDS-1:0]         in_bitmap,
   input  logic [NUM_FIELDS*4-1:0]       in_control,
   input  logic [NUM_FIELDS*WIDTH-1:0]   in_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [NUM_FIELDS*WIDTH-1:0]   out_header,
   output logic [NUM_FIELDS-1:0]         out_bitmap,
   output logic                          out_error,
   output logic [1:0]                    o_dbg_state
);

   // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
   localparam int IW = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NUM_FIELDS - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_next;
   logic [WIDTH-1:0]      r_field [NUM_FIELDS];
   logic [WIDTH-1:0]      r_data  [NUM_FIELDS];
   logic [3:0]            r_ctrl  [NUM_FIELDS];
   logic [NUM_FIELDS-1:0] r_bitmap;
   logic                  r_error;
   logic [IW-1:0]         r_idx;

   logic [WIDTH-1:0]      w_cur_f;
   logic [WIDTH-1:0]      w_new_f;
   logic                  w_cur_b;
   logic                  w_new_b;
   logic                  w_err;

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (in_valid)            w_next = S_RUN;
         S_RUN:   if (r_idx == LAST_IDX)   w_next = S_DONE;
         S_DONE:  if (out_ready)           w_next = S_IDLE;
         default:                          w_next = S_IDLE;
      endcase
   end

   // in_ready is gated by rst so nothing looks acceptable while reset is applied.
   always_comb begin
      in_ready    = (r_state == S_IDLE) && !rst;
      out_valid   = (r_state == S_DONE);
      o_dbg_state = r_state;
   end

   always_comb begin
      w_cur_f = r_field[r_idx];
      w_cur_b = r_bitmap[r_idx];
      w_new_f = w_cur_f;
      w_new_b = w_cur_b;
      w_err   = 1'b0;
      case (r_ctrl[r_idx])
         4'b0000: ;
         4'b0001: w_new_b = 1'b0;
         4'b0010: begin
            w_new_f = r_data[r_idx];
            w_new_b = 1'b1;
         end
         4'b0011: begin
            if (w_cur_b) w_new_f = w_cur_f + WIDTH'(1);
            else         w_err   = 1'b1;
         end
         4'b0100: begin
            if (!w_cur_b)               w_err   = 1'b1;
            else if (w_cur_f != '0)     w_new_f = w_cur_f - WIDTH'(1);
         end
         default: begin
            w_new_f = '0;
            w_new_b = 1'b0;
            w_err   = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_FIELDS; i++) begin
            r_field[i] <= '0;
            r_data[i]  <= '0;
            r_ctrl[i]  <= '0;
         end
         r_bitmap <= '0;
         r_error  <= 1'b0;
         r_idx    <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  for (int i = 0; i < NUM_FIELDS; i++) begin
                     r_field[i] <= in_header[i*WIDTH +: WIDTH];
                     r_data[i]  <= in_data[i*WIDTH +: WIDTH];
                     r_ctrl[i]  <= in_control[i*4 +: 4];
                  end
                  r_bitmap <= in_bitmap;
                  r_error  <= 1'b0;
                  r_idx    <= '0;
               end
            end
            S_RUN: begin
               r_field[r_idx]  <= w_new_f;
               r_bitmap[r_idx] <= w_new_b;
               r_error         <= r_error | w_err;
               r_idx           <= (r_idx == LAST_IDX) ? '0 : r_idx + IW'(1);
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      out_header = '0;
      for (int i = 0; i < NUM_FIELDS; i++) out_header[i*WIDTH +: WIDTH] = r_field[i];
      out_bitmap = r_bitmap;
      out_error  = r_error;
   end

endmodule

// File: tb/tb_action_lu_seq.sv
// Bench for action_lu_seq: directed and random transactions checked by a
// queue-based scoreboard against a field-by-field reference model.
module tb_action_lu_seq;

   localparam int W  = 8;
   localparam int N  = 4;
   localparam int HW = W * N;
   localparam int PW = HW + N + 1;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            in_valid = 1'b0;
   logic            out_ready = 1'b1;
   logic [HW-1:0]   in_header = '0;
   logic [HW-1:0]   in_data = '0;
   logic [N-1:0]    in_bitmap = '0;
   logic [4*N-1:0]  in_control = '0;
   logic            in_ready;
   logic            out_valid;
   logic [HW-1:0]   out_header;
   logic [N-1:0]    out_bitmap;
   logic            out_error;
   logic [1:0]      dbg_state;

   int              n_vec = 0;
   int              n_miss = 0;
   int              cyc = 0;
   logic [PW-1:0]   exp_q[$];
   int              lat_q[$];
   logic            prev_v = 1'b0;

   action_lu_seq #(.WIDTH(W), .NUM_FIELDS(N)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_header(in_header), .in_bitmap(in_bitmap),
      .in_control(in_control), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_header(out_header), .out_bitmap(out_bitmap),
      .out_error(out_error), .o_dbg_state(dbg_state)
   );

   // clock / reset block
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
      $fatal(1);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // reference model: applies each field's action with plain integer arithmetic
   function automatic logic [PW-1:0] model(input logic [HW-1:0] h, input logic [N-1:0] b,
                                           input logic [4*N-1:0] c, input logic [HW-1:0] d);
      logic [HW-1:0] oh;
      logic [N-1:0]  ob;
      bit            err;
      int            f;
      bit            p;
      oh  = '0;
      ob  = '0;
      err = 1'b0;
      for (int i = 0; i < N; i++) begin
         f = int'(h[i*W +: W]);
         p = b[i];
         case (int'(c[i*4 +: 4]))
            0: ;
            1: p = 1'b0;
            2: begin f = int'(d[i*W +: W]); p = 1'b1; end
            3: if (p) f = (f + 1) % (2 ** W); else err = 1'b1;
            4: if (p) f = (f > 0) ? f - 1 : 0; else err = 1'b1;
            default: begin f = 0; p = 1'b0; err = 1'b1; end
         endcase
         oh[i*W +: W] = W'(f);
         ob[i]        = p;
      end
      return {err, ob, oh};
   endfunction

   // driver tasks
   task automatic send(input logic [HW-1:0] h, input logic [N-1:0] b,
                       input logic [4*N-1:0] c, input logic [HW-1:0] d);
      bit got;
      got = 1'b0;
      @(posedge clk); #1;
      in_header  = h;
      in_bitmap  = b;
      in_control = c;
      in_data    = d;
      in_valid   = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (in_ready) begin got = 1'b1; break; end
      end
      if (got) begin
         exp_q.push_back(model(h, b, c, d));
         lat_q.push_back(cyc);
      end else begin
         chk("capture_timeout", {63'd0, in_ready}, 64'd1);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0) break;
      end
      if (exp_q.size() != 0) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         lat_q.delete();
         prev_v = 1'b0;
      end else begin
         if (out_valid && !prev_v) begin
            if (lat_q.size() == 0) chk("spurious_valid", {63'd0, out_valid}, 64'd0);
            else                   chk("latency", 64'(cyc), 64'(lat_q.pop_front() + N + 1));
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("unexpected_output", {63'd0, out_valid}, 64'd0);
            else chk("result", 64'({out_error, out_bitmap, out_header}), 64'(exp_q.pop_front()));
         end
         prev_v = out_valid;
      end
   end

   initial begin
      logic [PW-1:0]  exp_bp;
      logic [HW-1:0]  h;
      logic [HW-1:0]  d;
      logic [N-1:0]   b;
      logic [4*N-1:0] c;

      // reset held with in_valid asserted
      in_valid  = 1'b1;
      in_header = $urandom;
      in_bitmap = 4'b1111;
      repeat (3) begin
         @(negedge clk);
         chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
         chk("rst_out_header", 64'(out_header), 64'd0);
         chk("rst_out_bitmap", 64'(out_bitmap), 64'd0);
         chk("rst_out_error", {63'd0, out_error}, 64'd0);
         chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
      end
      @(posedge clk); #1;
      rst      = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      chk("ready_after_reset", {63'd0, in_ready}, 64'd1);
      repeat (5) begin
         @(negedge clk);
         chk("no_capture_in_reset", {63'd0, in_ready}, 64'd1);
      end

      // mixed actions
      send(32'h44332211, 4'b1111, {4'h3, 4'h2, 4'h1, 4'h0}, 32'h00AA0000);
      wait_drain();
      // arithmetic bounds
      send(32'h770500FF, 4'b1111, {4'h0, 4'h4, 4'h4, 4'h3}, 32'h0);
      wait_drain();
      // illegal code and increment of an absent field, then a clean one
      send(32'h99887766, 4'b0111, {4'h3, 4'h8, 4'h0, 4'h0}, 32'h0);
      wait_drain();
      send(32'h12345678, 4'b1111, 16'h0000, 32'h0);
      wait_drain();

      // backpressure
      @(posedge clk); #1;
      out_ready = 1'b0;
      h = $urandom; d = $urandom;
      exp_bp = model(h, 4'b1011, {4'h3, 4'h4, 4'h2, 4'h1}, d);
      send(h, 4'b1011, {4'h3, 4'h4, 4'h2, 4'h1}, d);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (out_valid) break;
      end
      repeat (10) begin
         @(posedge clk); #1;
         in_valid   = 1'($urandom_range(0, 1));
         in_header  = $urandom;
         in_bitmap  = 4'($urandom);
         in_control = 16'($urandom);
         in_data    = $urandom;
         @(negedge clk);
         chk("bp_hold", 64'({out_error, out_bitmap, out_header}), 64'(exp_bp));
         chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
         chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
      end
      @(posedge clk); #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      @(negedge clk);
      chk("handoff_out_valid", {63'd0, out_valid}, 64'd0);
      chk("handoff_in_ready", {63'd0, in_ready}, 64'd1);
      chk("bp_no_capture", 64'(exp_q.size()), 64'd0);
      @(posedge clk); #1;
      out_ready = 1'b1;

      // reset during RUN
      send(32'hDEADBEEF, 4'b1111, {4'h2, 4'h3, 4'h4, 4'h2}, 32'h01020304);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (8) begin
         @(negedge clk);
         chk("abort_out_valid", {63'd0, out_valid}, 64'd0);
         chk("abort_outputs", 64'({out_error, out_bitmap, out_header}), 64'd0);
      end
      send(32'hA0B1C2D3, 4'b0110, {4'h4, 4'h3, 4'h3, 4'h4}, 32'h0);
      wait_drain();

      // randomized transactions with random backpressure
      repeat (40) begin
         h = $urandom;
         d = $urandom;
         b = 4'($urandom);
         for (int i = 0; i < N; i++) c[i*4 +: 4] = 4'($urandom_range(0, 6));
         if ($urandom_range(0, 7) == 0) c[3:0] = 4'($urandom_range(5, 15));
         send(h, b, c, d);
         for (int j = 0; j < 100 && exp_q.size() != 0; j++) begin
            @(posedge clk); #1;
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
         end
         if (exp_q.size() != 0) chk("rand_drain_timeout", 64'(exp_q.size()), 64'd0);
         @(posedge clk); #1;
         out_ready = 1'b1;
      end

      repeat (3) @(negedge clk);
      chk("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
